vga_timing_core: RTL and testbench
==================================

VGA_TIMING_CORE -- requirements
Module: vga_timing_core

Interface
REQ-001 Parameter RED_BITS, default 4: red channel width.
REQ-002 Parameter GREEN_BITS, default 4: green channel width.
REQ-003 Parameter BLUE_BITS, default 4: blue channel width.
REQ-004 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixel clocks, each >=1.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines, each >=1.
REQ-006 Parameters HSYNC_POL/VSYNC_POL, default 0/0: asserted sync level (0 = active-low).
REQ-007 Ports SHALL be:
clk  in  1  pixel clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  out  1  pixel request for coordinate req_x/req_y
req_x  out  XW  requested column, XW = clog2(H_ACTIVE)
req_y  out  YW  requested row, YW = clog2(V_ACTIVE)
red_in/green_in/blue_in  in  RED/GREEN/BLUE_BITS  pixel data, sampled one cycle after req_valid
red_out/green_out/blue_out  out  RED/GREEN/BLUE_BITS  registered pixel, zero outside active region
hsync_out/vsync_out  out  1  registered sync at configured polarity
de_out  out  1  registered data enable
line_start  out  1  one-cycle pulse, aligned to de_out, first active pixel of each line
frame_start  out  1  one-cycle pulse, aligned to de_out, pixel (0,0)

Function
REQ-008 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP), wrapping to 0.
REQ-009 v_cnt SHALL increment only when h_cnt wraps, counting 0..V_TOTAL-1 and wrapping to 0 simultaneously with h_cnt wrap at (H_TOTAL-1, V_TOTAL-1).
REQ-010 Region order per axis SHALL be active [0,ACTIVE), front porch, sync, back porch.
REQ-011 Stage 0: req_valid SHALL be combinational from counters, high iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; req_x=h_cnt, req_y=v_cnt when valid, else 0.
REQ-012 Stage 1: rgb_in SHALL be registered one cycle after its req_valid cycle; raw hsync/vsync/de SHALL be delayed alongside.
REQ-013 Stage 2: outputs SHALL be registered; total latency counter->outputs is exactly 2 clocks for rgb, syncs, de_out, line_start, frame_start.
REQ-014 rgb_out SHALL be forced to 0 whenever de_out is 0, regardless of rgb_in.
REQ-015 hsync asserted iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v_cnt, over entire lines.
REQ-016 Pixel count per frame SHALL be exactly H_ACTIVE*V_ACTIVE; no pixel duplicated or dropped at wrap.

Reset
REQ-017 While reset=1: h_cnt=v_cnt=0, pipeline flushed, de_out=0, rgb_out=0, line_start=frame_start=0, hsync_out=!HSYNC_POL, vsync_out=!VSYNC_POL.
REQ-018 Reset asserted mid-frame SHALL abort the frame; the first cycle after release SHALL present req_valid=1 at (0,0) and frame_start two cycles later.

Configuration
REQ-019 With VGA_TEST_PATTERN_EN defined: input pattern_sel (1 bit) added; when 1, stage 1 substitutes 8 vertical colour bars (bar = req_x*8/H_ACTIVE; bit0->blue, bit1->red, bit2->green, channel at full scale), ignoring rgb_in.
REQ-020 Without VGA_TEST_PATTERN_EN: pattern_sel absent, rgb_in always used, no bar logic synthesised.

Structure
REQ-021 Package vga_timing_pkg SHALL hold clog2 function, default 640x480@60 timing constants and 1280x1024@60 constants.
REQ-022 Sub-module vga_axis_counter (parameters ACTIVE/FP/SYNC/BP; wrap-enable input; count, active, sync, wrap outputs) SHALL be instantiated once per axis.

Verification (bench params H 8/2/2/2, V 4/1/1/1; H_TOTAL=14, V_TOTAL=7)
REQ-023 Reset held 5 cycles -> hsync_out=vsync_out=1 (POL=0), de_out=0, rgb_out=0.
REQ-024 Release reset, rgb_in=req_x -> de_out high 8 cycles per line starting 2 cycles after release, red_out 0..7, hsync_out low h_cnt 10..11 delayed by 2.
REQ-025 Run 2 frames -> frame_start every 98 cycles, line_start 4 per frame, 32 de_out cycles per frame, vsync_out low exactly 14 cycles.
REQ-026 Drive rgb_in=all-ones constantly -> rgb_out=0 whenever de_out=0.
REQ-027 Assert reset at h_cnt=5, v_cnt=2 for 1 cycle -> next req_valid at (0,0), frame_start 2 cycles later.
REQ-028 VGA_TEST_PATTERN_EN, pattern_sel=1 -> pixel x=7 outputs bar 7 (all channels max), x=0 all zero.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared clog2 helper and standard VGA timing constants
package vga_timing_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // 640x480@60
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 1280x1024@60
  localparam int SXGA_H_ACTIVE = 1280;
  localparam int SXGA_H_FP     = 48;
  localparam int SXGA_H_SYNC   = 112;
  localparam int SXGA_H_BP     = 248;
  localparam int SXGA_V_ACTIVE = 1024;
  localparam int SXGA_V_FP     = 1;
  localparam int SXGA_V_SYNC   = 3;
  localparam int SXGA_V_BP     = 38;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: counter plus active/sync region decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int CW    = clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrap_en,
  output logic [CW-1:0] count,
  output logic          active,
  output logic          sync,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  // wrap_en advances the count; the vertical axis is stepped by the horizontal wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wrap_en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign wrap   = wrap_en && (count == LAST);
  assign active = count < ACT_END;
  assign sync   = (count >= SYNC_START) && (count < SYNC_END);

endmodule

// File: rtl/vga_timing_core.sv
// rtl/vga_timing_core.sv - VGA raster timing with 2-stage pixel pipeline; VGA_TEST_PATTERN_EN adds colour bars
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int RED_BITS   = 4,
  parameter int GREEN_BITS = 4,
  parameter int BLUE_BITS  = 4,
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FP       = VGA640_H_FP,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BP       = VGA640_H_BP,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FP       = VGA640_V_FP,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BP       = VGA640_V_BP,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  localparam int XW = clog2(H_ACTIVE),
  localparam int YW = clog2(V_ACTIVE)
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                  pattern_sel,
`endif
  output logic                  req_valid,
  output logic [XW-1:0]         req_x,
  output logic [YW-1:0]         req_y,
  input  logic [RED_BITS-1:0]   red_in,
  input  logic [GREEN_BITS-1:0] green_in,
  input  logic [BLUE_BITS-1:0]  blue_in,
  output logic [RED_BITS-1:0]   red_out,
  output logic [GREEN_BITS-1:0] green_out,
  output logic [BLUE_BITS-1:0]  blue_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  de_out,
  output logic                  line_start,
  output logic                  frame_start
);

  localparam int HCW = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VCW = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic HPOL = (HSYNC_POL != 0);
  localparam logic VPOL = (VSYNC_POL != 0);

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic h_active, h_sync, h_wrap;
  logic v_active, v_sync, v_wrap_unused;

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .clk(clk), .reset(reset), .wrap_en(1'b1),
    .count(h_cnt), .active(h_active), .sync(h_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .clk(clk), .reset(reset), .wrap_en(h_wrap),
    .count(v_cnt), .active(v_active), .sync(v_sync), .wrap(v_wrap_unused)
  );

  // Stage 0: combinational pixel request straight off the counters
  logic raw_line_start, raw_frame_start;
  assign req_valid       = h_active && v_active;
  assign req_x           = req_valid ? h_cnt[XW-1:0] : '0;
  assign req_y           = req_valid ? v_cnt[YW-1:0] : '0;
  assign raw_line_start  = req_valid && (h_cnt == '0);
  assign raw_frame_start = raw_line_start && (v_cnt == '0);

  // Stage 1: controls wait here while the pixel source answers the request
  logic s1_de, s1_hs, s1_vs, s1_ls, s1_fs;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_de <= 1'b0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_ls <= 1'b0;
      s1_fs <= 1'b0;
    end else begin
      s1_de <= req_valid;
      s1_hs <= h_sync;
      s1_vs <= v_sync;
      s1_ls <= raw_line_start;
      s1_fs <= raw_frame_start;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  logic [2:0] s1_bar;
  assign bar = 3'((int'(req_x) * 8) / H_ACTIVE);
  always_ff @(posedge clk) begin
    if (reset) s1_bar <= '0;
    else       s1_bar <= bar;
  end
`endif

  logic [RED_BITS-1:0]   pix_r;
  logic [GREEN_BITS-1:0] pix_g;
  logic [BLUE_BITS-1:0]  pix_b;
  always_comb begin
    pix_r = red_in;
    pix_g = green_in;
    pix_b = blue_in;
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) begin
      pix_b = s1_bar[0] ? '1 : '0;
      pix_r = s1_bar[1] ? '1 : '0;
      pix_g = s1_bar[2] ? '1 : '0;
    end
`endif
  end

  // Stage 2: registered outputs; colour is blanked outside the active region
  always_ff @(posedge clk) begin
    if (reset) begin
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      de_out      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync_out   <= !HPOL;
      vsync_out   <= !VPOL;
    end else begin
      red_out     <= s1_de ? pix_r : '0;
      green_out   <= s1_de ? pix_g : '0;
      blue_out    <= s1_de ? pix_b : '0;
      de_out      <= s1_de;
      line_start  <= s1_ls;
      frame_start <= s1_fs;
      hsync_out   <= s1_hs ? HPOL : !HPOL;
      vsync_out   <= s1_vs ? VPOL : !VPOL;
    end
  end

endmodule

// File: tb/tb_vga_timing_core.sv
// tb/tb_vga_timing_core.sv - directed bench for vga_timing_core on an 8x4 raster; VGA_TEST_PATTERN_EN adds bar checks
module tb_vga_timing_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid;
  logic [2:0] req_x;
  logic [1:0] req_y;
  logic [3:0] red_in, green_in, blue_in;
  logic [3:0] red_out, green_out, blue_out;
  logic       hsync_out, vsync_out, de_out, line_start, frame_start;
  logic       ones_mode = 1'b1;
  logic [2:0] mem_x;
`ifdef VGA_TEST_PATTERN_EN
  logic       pattern_sel = 1'b0;
`endif

  // One-cycle-latency pixel source returning the requested column as colour
  always @(posedge clk) mem_x <= req_x;
  assign red_in   = ones_mode ? 4'hF : {1'b0, mem_x};
  assign green_in = ones_mode ? 4'hF : {1'b0, mem_x};
  assign blue_in  = ones_mode ? 4'hF : {1'b0, mem_x};

  vga_timing_core #(
    .RED_BITS(4), .GREEN_BITS(4), .BLUE_BITS(4),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut (
    .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .line_start(line_start), .frame_start(frame_start)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       de;
    logic [3:0] red;
    logic       hs, vs, ls, fs;
  } vec_t;

  vec_t vecs[17];

  int fs_n, fs0, fs1, ls_n, de_n, on_ok, off_bad, vs_low, vs_first, hs_low;
  bit found;

  initial begin
    // Outputs k cycles after release reflect h_cnt = k-2 of line 0
    vecs = '{
      '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0}
    };

    // Reset held with all-ones input
    reset = 1'b1;
    ones_mode = 1'b1;
    repeat (5) @(negedge clk);
    check("reset hsync", 32'(hsync_out), 32'd1);
    check("reset vsync", 32'(vsync_out), 32'd1);
    check("reset de", 32'(de_out), 32'd0);
    check("reset rgb", 32'({red_out, green_out, blue_out}), 32'd0);
    check("reset pulses", 32'({line_start, frame_start}), 32'd0);

    // First line after release, rgb_in = req_x
    ones_mode = 1'b0;
    reset = 1'b0;
    check("release req", 32'({req_valid, req_x, req_y}), 32'({1'b1, 3'd0, 2'd0}));
    for (int k = 0; k < 17; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("line0 k=%0d", k),
            32'({de_out, red_out, hsync_out, vsync_out, line_start, frame_start}),
            32'({vecs[k].de, vecs[k].red, vecs[k].hs, vecs[k].vs, vecs[k].ls, vecs[k].fs}));
    end

    // Two full frames with constant all-ones input
    reset = 1'b1;
    ones_mode = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fs_n = 0; fs0 = -1; fs1 = -1; ls_n = 0; de_n = 0; on_ok = 0; off_bad = 0;
    vs_low = 0; vs_first = -1; hs_low = 0;
    for (int k = 0; k < 198; k++) begin
      if (k > 0) @(negedge clk);
      if (frame_start) begin
        if (fs_n == 0) fs0 = k;
        else if (fs_n == 1) fs1 = k;
        fs_n++;
      end
      if (line_start) ls_n++;
      if (de_out) begin
        de_n++;
        if ({red_out, green_out, blue_out} == 12'hFFF) on_ok++;
      end else if ({red_out, green_out, blue_out} != 12'h000) begin
        off_bad++;
      end
      if (!vsync_out) begin
        vs_low++;
        if (vs_first < 0) vs_first = k;
      end
      if (!hsync_out) hs_low++;
    end
    check("frame_start count", 32'(fs_n), 32'd2);
    check("frame_start first", 32'(fs0), 32'd2);
    check("frame_start period", 32'(fs1 - fs0), 32'd98);
    check("line_start count", 32'(ls_n), 32'd8);
    check("de cycles", 32'(de_n), 32'd64);
    check("rgb during de", 32'(on_ok), 32'd64);
    check("rgb blanked", 32'(off_bad), 32'd0);
    check("vsync low cycles", 32'(vs_low), 32'd28);
    check("vsync low start", 32'(vs_first), 32'd72);
    check("hsync low cycles", 32'(hs_low), 32'd28);

    // One-cycle reset at h_cnt=5, v_cnt=2
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (req_valid && req_x == 3'd5 && req_y == 2'd2) found = 1'b1;
    end
    check("mid reset target seen", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid release req", 32'({req_valid, req_x, req_y}), 32'({1'b1, 3'd0, 2'd0}));
    check("mid k0 de/fs", 32'({de_out, frame_start}), 32'd0);
    @(negedge clk);
    check("mid k1 de/fs", 32'({de_out, frame_start}), 32'd0);
    @(negedge clk);
    check("mid k2 de/ls/fs", 32'({de_out, line_start, frame_start}), 32'b111);

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars with all-ones input that must be ignored
    pattern_sel = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (req_valid && req_x == 3'd0) found = 1'b1;
    end
    check("bar line seen", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    check("bar x0", 32'({de_out, red_out, green_out, blue_out}), 32'({1'b1, 12'h000}));
    repeat (3) @(negedge clk);
    check("bar x3", 32'({de_out, red_out, green_out, blue_out}), 32'({1'b1, 12'hF0F}));
    repeat (4) @(negedge clk);
    check("bar x7", 32'({de_out, red_out, green_out, blue_out}), 32'({1'b1, 12'hFFF}));
    pattern_sel = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
